// File: rtl/risc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// risc_ctrl_fsm_if : control bundle between the RiSC-16 multi-cycle control
// FSM and the datapath / unified memory.
//   master (control FSM) : drives ALU select, memory handshake, IR/PC/RF
//                          strobes, mux selects and halted; samples opcode,
//                          imm_nz, alu_stat, mem_ready.
//   slave  (datapath)    : the mirror image.
// ALU function encodings (FUNCT_LEN = 2): ADD = 0, SUB = 1, NAND = 2,
// PASSA = 3.
// ---------------------------------------------------------------------------
interface risc_ctrl_fsm_if #(
    parameter int OPC_LEN   = 3,
    parameter int PCSEL_LEN = 2,
    parameter int WSEL_LEN  = 2,
    parameter int FUNCT_LEN = 2
);
    logic [OPC_LEN-1:0]   opcode;
    logic                 imm_nz;
    logic                 alu_stat;
    logic                 mem_ready;
    logic [FUNCT_LEN-1:0] alu_funct;
    logic                 alu_bsrc;
    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_asel;
    logic                 ir_we;
    logic                 pc_we;
    logic [PCSEL_LEN-1:0] pc_src;
    logic                 rf_we;
    logic [WSEL_LEN-1:0]  rf_wsel;
    logic                 halted;

    modport master (
        input  opcode, imm_nz, alu_stat, mem_ready,
        output alu_funct, alu_bsrc, mem_req, mem_we, mem_asel, ir_we,
               pc_we, pc_src, rf_we, rf_wsel, halted
    );

    modport slave (
        output opcode, imm_nz, alu_stat, mem_ready,
        input  alu_funct, alu_bsrc, mem_req, mem_we, mem_asel, ir_we,
               pc_we, pc_src, rf_we, rf_wsel, halted
    );
endinterface

// File: rtl/risc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// risc_ctrl_fsm : multi-cycle control unit for the non-pipelined RiSC-16.
// Sequences RESET -> FETCH -> DECODE -> EXEC -> (MEM | WB) -> FETCH, or
// DECODE -> HALT for JALR with a non-zero immediate.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (state cleared to RESET)
//   bus   : risc_ctrl_fsm_if.master, all datapath/memory control
// Outputs are combinational from state and inputs so that an asserted
// reset removes every strobe immediately, without waiting for a clock.
// ---------------------------------------------------------------------------
module risc_ctrl_fsm #(
    parameter int OPC_LEN   = 3,
    parameter int PCSEL_LEN = 2,
    parameter int WSEL_LEN  = 2,
    parameter int FUNCT_LEN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    risc_ctrl_fsm_if.master    bus
);

    localparam logic [OPC_LEN-1:0] OP_ADD  = 3'd0;
    localparam logic [OPC_LEN-1:0] OP_ADDI = 3'd1;
    localparam logic [OPC_LEN-1:0] OP_NAND = 3'd2;
    localparam logic [OPC_LEN-1:0] OP_LUI  = 3'd3;
    localparam logic [OPC_LEN-1:0] OP_SW   = 3'd4;
    localparam logic [OPC_LEN-1:0] OP_LW   = 3'd5;
    localparam logic [OPC_LEN-1:0] OP_BEQ  = 3'd6;
    localparam logic [OPC_LEN-1:0] OP_JALR = 3'd7;

    localparam logic [FUNCT_LEN-1:0] FUNCT_ADD   = 2'd0;
    localparam logic [FUNCT_LEN-1:0] FUNCT_SUB   = 2'd1;
    localparam logic [FUNCT_LEN-1:0] FUNCT_NAND  = 2'd2;
    localparam logic [FUNCT_LEN-1:0] FUNCT_PASSA = 2'd3;

    localparam logic [PCSEL_LEN-1:0] PC_INC = 2'd0;
    localparam logic [PCSEL_LEN-1:0] PC_BR  = 2'd1;
    localparam logic [PCSEL_LEN-1:0] PC_ALU = 2'd2;

    localparam logic [WSEL_LEN-1:0] WS_ALU = 2'd0;
    localparam logic [WSEL_LEN-1:0] WS_MEM = 2'd1;
    localparam logic [WSEL_LEN-1:0] WS_PC  = 2'd2;
    localparam logic [WSEL_LEN-1:0] WS_LUI = 2'd3;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    state_e state_q;
    state_e state_d;

    // State register, cleared asynchronously to RESET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; every output defaults to 0 so selects
    // are never X when their enable is low.
    always_comb begin
        state_d       = state_q;
        bus.alu_funct = FUNCT_ADD;
        bus.alu_bsrc  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_asel  = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = PC_INC;
        bus.rf_we     = 1'b0;
        bus.rf_wsel   = WS_ALU;
        bus.halted    = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = ST_DECODE;
                end else begin
                    state_d   = ST_FETCH;
                end
            end

            ST_DECODE: begin
                // JALR with a non-zero immediate is the HALT encoding.
                if ((bus.opcode == OP_JALR) && bus.imm_nz) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (bus.opcode)
                    OP_ADD: begin
                        state_d = ST_WB;
                    end
                    OP_ADDI: begin
                        bus.alu_bsrc = 1'b1;
                        state_d      = ST_WB;
                    end
                    OP_NAND: begin
                        bus.alu_funct = FUNCT_NAND;
                        state_d       = ST_WB;
                    end
                    OP_LUI: begin
                        bus.rf_we   = 1'b1;
                        bus.rf_wsel = WS_LUI;
                        state_d     = ST_FETCH;
                    end
                    OP_SW, OP_LW: begin
                        bus.alu_bsrc = 1'b1;
                        state_d      = ST_MEM;
                    end
                    OP_BEQ: begin
                        bus.alu_funct = FUNCT_SUB;
                        if (bus.alu_stat) begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = PC_BR;
                        end else begin
                            bus.pc_we  = 1'b0;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_JALR: begin
                        // Link (PC already incremented) and jump in one cycle;
                        // PC takes regB before the RF edge updates it.
                        bus.alu_funct = FUNCT_PASSA;
                        bus.rf_we     = 1'b1;
                        bus.rf_wsel   = WS_PC;
                        bus.pc_we     = 1'b1;
                        bus.pc_src    = PC_ALU;
                        state_d       = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_RESET;
                    end
                endcase
            end

            ST_MEM: begin
                // Address (rB + imm7) held stable for the whole access.
                bus.mem_req  = 1'b1;
                bus.mem_asel = 1'b1;
                bus.alu_bsrc = 1'b1;
                bus.mem_we   = (bus.opcode == OP_SW);
                if (bus.mem_ready) begin
                    if (bus.opcode == OP_LW) begin
                        bus.rf_we   = 1'b1;
                        bus.rf_wsel = WS_MEM;
                    end else begin
                        bus.rf_we   = 1'b0;
                    end
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end

            ST_WB: begin
                if (bus.opcode == OP_NAND) begin
                    bus.alu_funct = FUNCT_NAND;
                end else begin
                    bus.alu_funct = FUNCT_ADD;
                end
                bus.alu_bsrc = (bus.opcode == OP_ADDI);
                bus.rf_we    = 1'b1;
                bus.rf_wsel  = WS_ALU;
                state_d      = ST_FETCH;
            end

            ST_HALT: begin
                bus.halted = 1'b1;
                state_d    = ST_HALT;
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_risc_ctrl_fsm : directed self-checking bench for risc_ctrl_fsm.
// Each cycle the full output vector is compared against a hand-built
// expected vector {halted, rf_wsel, rf_we, pc_src, pc_we, ir_we, mem_asel,
// mem_we, mem_req, alu_bsrc, alu_funct}. Funct: ADD 0, SUB 1, NAND 2, PASSA 3.
// ---------------------------------------------------------------------------
module tb_risc_ctrl_fsm;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    risc_ctrl_fsm_if #(.OPC_LEN(3), .PCSEL_LEN(2), .WSEL_LEN(2), .FUNCT_LEN(2)) bus ();

    risc_ctrl_fsm #(.OPC_LEN(3), .PCSEL_LEN(2), .WSEL_LEN(2), .FUNCT_LEN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Build an expected output vector from named fields.
    function automatic logic [13:0] ov(input logic h, input logic [1:0] wsel,
                                       input logic rfwe, input logic [1:0] psrc,
                                       input logic pcwe, input logic irwe,
                                       input logic asel, input logic mwe,
                                       input logic mreq, input logic bsrc,
                                       input logic [1:0] fn);
        return {h, wsel, rfwe, psrc, pcwe, irwe, asel, mwe, mreq, bsrc, fn};
    endfunction

    function automatic logic [13:0] pack();
        return {bus.halted, bus.rf_wsel, bus.rf_we, bus.pc_src, bus.pc_we,
                bus.ir_we, bus.mem_asel, bus.mem_we, bus.mem_req,
                bus.alu_bsrc, bus.alu_funct};
    endfunction

    logic [13:0] Z;    // RESET / DECODE: nothing asserted
    logic [13:0] FA;   // FETCH accepted
    logic [13:0] FW;   // FETCH waiting

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leave the DUT in RESET state at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        rst_n         = 1'b0;
        bus.opcode    = 3'd7;
        bus.imm_nz    = 1'b0;
        bus.alu_stat  = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            obs = pack();
            checks++;
            if (obs !== Z) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %h expected %h", i, obs, Z);
            end
        end
    endtask

    task automatic test_rtype();
        logic [13:0] e[$];
        logic [13:0] obs;
        logic [1:0]  fn;
        logic        bs;
        for (int op = 0; op < 3; op++) begin
            fn = (op == 2) ? 2'd2 : 2'd0;
            bs = (op == 1) ? 1'b1 : 1'b0;
            e = '{Z, FA, Z, ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bs, fn),
                  ov(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bs, fn), FA};
            bus.opcode = 3'(op);
            do_reset();
            foreach (e[i]) begin
                bus.mem_ready = 1'b1;
                #1;
                obs = pack();
                checks++;
                if (obs !== e[i]) begin
                    errors++;
                    $display("FAIL rtype op%0d cyc%0d: got %h expected %h", op, i, obs, e[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [13:0] e[$];
        logic        r[$];
        logic [13:0] obs;
        logic [13:0] mw;
        mw = ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        e = '{Z, FW, FW, FA, Z, ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0),
              mw, mw, mw, ov(1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0), FA};
        r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.opcode = 3'd5;
        do_reset();
        foreach (e[i]) begin
            bus.mem_ready = r[i];
            #1;
            obs = pack();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL lw_wait cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_beq();
        logic [13:0] e[$];
        logic [13:0] obs;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                e = '{Z, FA, Z, ov(1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1), FA};
            end else begin
                e = '{Z, FA, Z, ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1), FA};
            end
            bus.opcode   = 3'd6;
            bus.alu_stat = (t == 0);
            do_reset();
            foreach (e[i]) begin
                bus.mem_ready = 1'b1;
                #1;
                obs = pack();
                checks++;
                if (obs !== e[i]) begin
                    errors++;
                    $display("FAIL beq taken=%0d cyc%0d: got %h expected %h", (t == 0), i, obs, e[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_jalr_halt();
        logic [13:0] e[$];
        logic [13:0] obs;
        logic [13:0] hv;
        e = '{Z, FA, Z, ov(1'b0, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3), FA};
        bus.opcode = 3'd7;
        bus.imm_nz = 1'b0;
        do_reset();
        foreach (e[i]) begin
            bus.mem_ready = 1'b1;
            #1;
            obs = pack();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL jalr cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick();
        end
        // HALT encoding: terminal, mem_ready toggling has no effect.
        hv = ov(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        e = '{Z, FA, Z, hv, hv, hv, hv, hv, hv, hv, hv, hv, hv, hv, hv};
        bus.imm_nz = 1'b1;
        do_reset();
        foreach (e[i]) begin
            bus.mem_ready = (i < 3) ? 1'b1 : 1'(i % 2);
            #1;
            obs = pack();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL halt cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick();
        end
        bus.imm_nz = 1'b0;
    endtask

    task automatic test_reset_mid_sw();
        logic [13:0] e[$];
        logic        r[$];
        logic [13:0] obs;
        logic [13:0] msw;
        msw = ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
        e = '{Z, FA, Z, ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), msw};
        bus.opcode = 3'd4;
        do_reset();
        foreach (e[i]) begin
            bus.mem_ready = (i == 4) ? 1'b0 : 1'b1;
            #1;
            obs = pack();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sw_pre cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick();
        end
        // Still waiting in MEM; pull reset between clock edges.
        bus.mem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        obs = pack();
        checks++;
        if (obs !== Z) begin
            errors++;
            $display("FAIL async_reset_drop: got %h expected %h", obs, Z);
        end
        tick();
        rst_n = 1'b1;
        e = '{Z, FW, FW, FA, Z};
        r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        foreach (e[i]) begin
            bus.mem_ready = r[i];
            #1;
            obs = pack();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sw_post_reset cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_sw_zero_wait();
        logic [13:0] e[$];
        logic [13:0] obs;
        e = '{Z, FA, Z, ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0),
              ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0), FA, Z};
        bus.opcode = 3'd4;
        do_reset();
        foreach (e[i]) begin
            bus.mem_ready = 1'b1;
            #1;
            obs = pack();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL sw_zero_wait cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] e[$];
        logic [13:0] obs;
        logic [13:0] lui;
        lui = ov(1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        e = '{Z, FA, Z, lui, FA, Z, lui, FA};
        bus.opcode = 3'd3;
        do_reset();
        foreach (e[i]) begin
            bus.mem_ready = 1'b1;
            #1;
            obs = pack();
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL lui_b2b cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.opcode    = 3'd0;
        bus.imm_nz    = 1'b0;
        bus.alu_stat  = 1'b0;
        bus.mem_ready = 1'b0;
        Z  = ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        FA = ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        FW = ov(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        test_reset();
        bus.alu_stat = 1'b0;
        test_rtype();
        test_lw_wait();
        test_beq();
        test_jalr_halt();
        test_reset_mid_sw();
        test_sw_zero_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_ctrl_fsm.md
Name: risc_ctrl_fsm

Overview:
Multi-cycle control unit for the non-pipelined RiSC-16 core. It sits directly upstream of the ALU and drives its function select. It consumes the ALU zero status for branch resolution and sequences fetch, decode, execute, memory and writeback. It also drives all datapath enables and mux selects, and handshakes with a variable-latency unified memory.

Parameters:
OPC_LEN, 3, opcode width (instr[15:13])
PCSEL_LEN, 2, width of pc_src
WSEL_LEN, 2, width of rf_wsel

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPC_LEN  instr[15:13] from IR
imm_nz  in  1  instr[6:0] != 0, used for HALT detection
alu_stat  in  1  ALU zero flag (out == 0)
mem_ready  in  1  memory completion strobe
alu_funct  out  `FUNCT_LEN  ALU function, `FUNCT_* encodings from defines.v
alu_bsrc  out  1  0 = regB, 1 = sign-extended imm7
mem_req  out  1  memory request
mem_we  out  1  memory write (valid only with mem_req)
mem_asel  out  1  0 = PC, 1 = ALU out
ir_we  out  1  IR load
pc_we  out  1  PC load
pc_src  out  PCSEL_LEN  0 = PC+1, 1 = PC+imm7 (branch), 2 = ALU out
rf_we  out  1  register file write
rf_wsel  out  WSEL_LEN  0 = ALU, 1 = mem rdata, 2 = PC, 3 = imm10<<6
halted  out  1  core halted

Behaviour:
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT. State register is async-cleared to RESET while rst_n = 0.
- Outputs are combinational from state, opcode, alu_stat and mem_ready. In RESET every output is 0.
- RESET -> FETCH unconditionally after reset deassertion (one idle cycle).
- FETCH: mem_req = 1, mem_asel = 0, mem_we = 0.
  - While mem_ready = 0, stay in FETCH and keep mem_req high.
  - On a cycle with mem_ready = 1: ir_we = 1, pc_we = 1, pc_src = 0, next state DECODE.
- DECODE: no strobes; one cycle for register read. Next state: EXEC, or HALT if opcode = JALR and imm_nz = 1.
- EXEC, by opcode:
  - ADD (000): funct ADD, bsrc 0 -> WB.
  - ADDI (001): funct ADD, bsrc 1 -> WB.
  - NAND (010): funct NAND, bsrc 0 -> WB.
  - LUI (011): rf_we = 1, rf_wsel = 3 -> FETCH.
  - SW (100) / LW (101): funct ADD, bsrc 1 -> MEM.
  - BEQ (110): funct SUB, bsrc 0. If alu_stat = 1, pc_we = 1 and pc_src = 1. -> FETCH.
  - JALR (111): funct PASSA on regB. rf_we = 1, rf_wsel = 2 (PC already incremented), pc_we = 1, pc_src = 2, all in the same cycle. -> FETCH.
  - JALR with rA = rB: the PC takes the pre-write regB value because the RF writes at the clock edge.
- MEM: mem_req = 1, mem_asel = 1, funct ADD, bsrc 1 held stable. mem_we = 1 for SW.
  - Stay in MEM until mem_ready = 1.
  - On mem_ready, LW: rf_we = 1, rf_wsel = 1. Then -> FETCH.
- WB: funct and bsrc as in EXEC, rf_we = 1, rf_wsel = 0 -> FETCH.
- HALT: halted = 1, all strobes 0, terminal until reset.
- mem_ready is ignored when mem_req = 0.
- mem_req never drops between assertion and acceptance.
- All mux selects are don't-care when their enable is low, but must be driven to 0 (no X).
- Latency with zero-wait memory (mem_ready tied 1), instruction to next FETCH:
  - ADD/ADDI/NAND: 4 cycles.
  - LUI/BEQ/JALR: 3 cycles.
  - LW/SW: 4 cycles.
- Each wait cycle adds 1.
- Reset mid-operation: immediate return to RESET, all outputs 0 asynchronously. No partial write may occur.
- The register file must ignore writes to r0; this block does not special-case r0.

Test Plan:
1. Reset, mem_ready = 1, opcode = 000 -> states RESET, FETCH, DECODE, EXEC, WB, FETCH. rf_we = 1 only in WB with rf_wsel = 0 and funct = ADD.
2. opcode = 101, mem_ready held 0 for 3 cycles in MEM -> mem_req = 1, mem_asel = 1 for 4 cycles. rf_we = 1, rf_wsel = 1 only in the mem_ready cycle, then FETCH.
3. opcode = 110 run twice, alu_stat = 1 then alu_stat = 0 -> EXEC has funct SUB. First run: pc_we = 1, pc_src = 1. Second run: pc_we = 0.
4. opcode = 111, imm_nz = 0 -> EXEC shows rf_we = 1, rf_wsel = 2, pc_we = 1, pc_src = 2, funct PASSA. With imm_nz = 1: DECODE -> HALT, halted = 1 for 10+ cycles regardless of mem_ready.
5. Assert rst_n = 0 mid-MEM during an SW wait -> mem_req and mem_we drop in the same cycle without waiting for clk. After release: one RESET cycle, then FETCH with pc_we = 0 until mem_ready.
6. opcode = 100 with mem_ready = 1 -> MEM asserts mem_we = 1 for exactly one cycle, rf_we = 0 throughout.
